player_laser: RTL and testbench

- Player-shot controller; consumes the player cannon X position and the same USB keycode byte that drives player movement.
- On a fire-key press, launches a single laser from the cannon and moves it up one step per frame.
- Retires the laser on a collision-unit hit or when it leaves the top of the screen, then enforces a cooldown.
- Outputs feed the sprite renderer, the collision unit and the score/sound logic.

---
 rtl/space_invaders_pkg.sv | 24 ++
 rtl/player_laser_key_edge_detect.sv | 31 +++
 rtl/player_laser.sv | 129 ++++++++++++
 tb/tb_player_laser.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders blocks: keycodes, screen
// bounds and the player-laser state encoding.
package space_invaders_pkg;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [9:0] X_MIN    = 10'd20;
  localparam logic [9:0] X_MAX    = 10'd600;
  localparam logic [9:0] SCREEN_H = 10'd480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } laser_state_t;

  // A zero cooldown still spends one frame in COOL.
  function automatic logic [7:0] cool_load(input logic [7:0] frames);
    return (frames == 8'd0) ? 8'd1 : frames;
  endfunction

endpackage

// File: rtl/player_laser_key_edge_detect.sv
// key_edge_detect: flags when the current keycode matches KEY (level_o)
// and the first frame of a press (rise_o). Reusable by any key-driven block.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous, active-high reset
//   keycode_i  current USB keycode
//   level_o    keycode_i == KEY this frame
//   rise_o     level_o high now but low on the previous edge
module key_edge_detect #(
  parameter logic [7:0] KEY = 8'h2C
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] keycode_i,
  output logic       level_o,
  output logic       rise_o
);

  logic prev_q;

  assign level_o = (keycode_i == KEY);
  assign rise_o  = level_o & ~prev_q;

  // Tracks the key on every edge regardless of what the consumer is doing,
  // so a key held across a busy period never looks like a fresh press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= level_o;
  end

endmodule

// File: rtl/player_laser.sv
// player_laser: player-shot controller. A fire-key press launches a single
// laser from the cannon; it climbs LASER_STEP rows per frame until a hit or
// until it would leave the top of the screen, then a cooldown runs before
// the next shot is allowed.
// Optional build macro: PLAYER_LASER_AUTOFIRE_EN makes the fire key
// level-sensitive in IDLE (holding it refires after each cooldown).
// Ports:
//   frame_clk     frame-rate clock (vsync)
//   Reset         asynchronous, active-high reset
//   keycode       current USB keycode
//   player_X      cannon left X
//   hit           laser collided this frame (only honoured in FLY)
//   laser_X       laser column (frozen for the whole flight)
//   laser_Y       laser row
//   laser_active  laser visible/collidable
//   fire_evt      one-frame pulse on launch
//   dbg_state     current FSM state
module player_laser
  import space_invaders_pkg::*;
#(
  parameter logic [9:0] LASER_Y_START   = 10'd440,
  parameter logic [9:0] LASER_Y_MIN     = 10'd8,
  parameter logic [9:0] LASER_STEP      = 10'd4,
  parameter logic [9:0] X_OFFSET        = 10'd10,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd15,
  parameter logic [7:0] FIRE_KEY        = KEY_SPACE
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic [7:0]   keycode,
  input  logic [9:0]   player_X,
  input  logic         hit,
  output logic [9:0]   laser_X,
  output logic [9:0]   laser_Y,
  output logic         laser_active,
  output logic         fire_evt,
  output laser_state_t dbg_state
);

  laser_state_t state_q, state_d;
  logic [9:0]   x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic         active_q, active_d;
  logic         fire_q, fire_d;
  logic [7:0]   cool_q, cool_d;

  logic key_level;
  logic key_rise;
  logic fire_cond;
  logic retire;

  key_edge_detect #(.KEY(FIRE_KEY)) u_fire_key (
    .clk_i    (frame_clk),
    .rst_i    (Reset),
    .keycode_i(keycode),
    .level_o  (key_level),
    .rise_o   (key_rise)
  );

`ifdef PLAYER_LASER_AUTOFIRE_EN
  // rise implies level, so this is just the level; OR-ing keeps the
  // edge output connected in this build.
  assign fire_cond = key_level | key_rise;
`else
  assign fire_cond = key_rise;
`endif

  // Retire check comes before the subtract so laser_Y can never underflow.
  assign retire = hit || (y_q < (LASER_Y_MIN + LASER_STEP));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= 10'd0;
      y_q      <= LASER_Y_START;
      active_q <= 1'b0;
      fire_q   <= 1'b0;
      cool_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      fire_q   <= fire_d;
      cool_q   <= cool_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    fire_d   = 1'b0;
    cool_d   = cool_q;
    unique case (state_q)
      IDLE: begin
        if (fire_cond) begin
          x_d      = player_X + X_OFFSET;
          y_d      = LASER_Y_START;
          active_d = 1'b1;
          fire_d   = 1'b1;
          state_d  = FLY;
        end
      end
      FLY: begin
        if (retire) begin
          active_d = 1'b0;
          cool_d   = cool_load(COOLDOWN_FRAMES);
          state_d  = COOL;
        end else begin
          y_d = y_q - LASER_STEP;
        end
      end
      COOL: begin
        if (cool_q <= 8'd1) state_d = IDLE;
        else                cool_d  = cool_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign laser_X      = x_q;
  assign laser_Y      = y_q;
  assign laser_active = active_q;
  assign fire_evt     = fire_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_player_laser.sv
module tb_player_laser;
  import space_invaders_pkg::*;

  localparam int W = 22;
`ifdef PLAYER_LASER_AUTOFIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // clock / reset
  logic         frame_clk = 1'b0;
  logic         Reset     = 1'b1;
  logic [7:0]   keycode   = 8'd0;
  logic [9:0]   player_X  = 10'd0;
  logic         hit       = 1'b0;
  logic [9:0]   laser_X;
  logic [9:0]   laser_Y;
  logic         laser_active;
  logic         fire_evt;
  laser_state_t dbg_state;

  always #5 frame_clk = ~frame_clk;

  player_laser dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .player_X    (player_X),
    .hit         (hit),
    .laser_X     (laser_X),
    .laser_Y     (laser_Y),
    .laser_active(laser_active),
    .fire_evt    (fire_evt),
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int passed = 0;
  int dut_fires = 0;
  logic [W-1:0] exp_q[$];

  // reference model: one laser, a countdown of cooldown frames left
  bit m_active;
  int m_cool_left;
  int m_x;
  int m_y;
  bit m_prev;
  bit m_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_active    = 1'b0;
    m_cool_left = 0;
    m_x         = 0;
    m_y         = 440;
    m_prev      = 1'b0;
    m_fire      = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] k, input logic [9:0] px, input logic h);
    bit kf;
    kf     = (k == 8'h2C);
    m_fire = 1'b0;
    if (m_active) begin
      // retire when hit or when the next step would pass the top row
      if (h || (m_y - 4 < 8)) begin
        m_active    = 1'b0;
        m_cool_left = 15;
      end else begin
        m_y = m_y - 4;
      end
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (kf && (AUTO || !m_prev)) begin
      m_active = 1'b1;
      m_fire   = 1'b1;
      m_x      = (int'(px) + 10) % 1024;
      m_y      = 440;
    end
    m_prev = kf;
  endfunction

  // driver
  task automatic frame(input logic [7:0] k, input logic [9:0] px, input logic h);
    logic [9:0] ex;
    logic [9:0] ey;
    @(negedge frame_clk);
    keycode  = k;
    player_X = px;
    hit      = h;
    model_step(k, px, h);
    ex = m_x[9:0];
    ey = m_y[9:0];
    exp_q.push_back({m_fire, m_active, ex, ey});
  endtask

  task automatic drain();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic idle_out(input logic [9:0] px);
    for (int i = 0; i < 300 && (m_active || m_cool_left != 0); i++) frame(8'd0, px, 1'b0);
    check("idle_out_bound", {31'd0, (m_active || m_cool_left != 0)}, 32'd0);
    frame(8'd0, px, 1'b0);
  endtask

  task automatic fly_to(input int target, input logic [9:0] px);
    for (int i = 0; i < 200 && m_y != target; i++) frame(8'd0, px, 1'b0);
    check("fly_to_bound", m_y, target);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_active"}, {31'd0, laser_active}, 32'd0);
    check({tag, "_y"}, {22'd0, laser_Y}, 32'd440);
    check({tag, "_x"}, {22'd0, laser_X}, 32'd0);
    check({tag, "_fire"}, {31'd0, fire_evt}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // scoreboard monitor
  always @(posedge frame_clk) begin
    logic [W-1:0] e;
    #1;
    if (!Reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_out", {10'd0, fire_evt, laser_active, laser_X, laser_Y}, {10'd0, e});
      if (fire_evt) dut_fires++;
    end
  end

  initial begin
    int base;
    logic [7:0] rk;
    model_reset();

    // reset state
    #12;
    check_reset_state("reset");
    @(negedge frame_clk);
    Reset = 1'b0;

    // launch, first step, full flight with player moving, cooldown
    frame(8'd0, 10'd320, 1'b0);
    frame(8'h2C, 10'd320, 1'b0);
    frame(8'd0, 10'd320, 1'b0);
    for (int i = 0; i < 60; i++) frame(8'd0, 10'd320, 1'b0);
    for (int i = 0; i < 60; i++) frame(8'd0, 10'd400, 1'b0);
    drain();
    check("frozen_x", {22'd0, laser_X}, 32'd330);
    for (int i = 0; i < 20; i++) frame(8'd0, 10'd400, 1'b0);
    frame(8'h2C, 10'd50, 1'b0);

    // hit at row 300, press during cooldown ignored, later press fires
    fly_to(300, 10'd50);
    frame(8'd0, 10'd50, 1'b1);
    for (int i = 0; i < 9; i++) frame(8'd0, 10'd50, 1'b0);
    frame(8'h2C, 10'd50, 1'b0);
    for (int i = 0; i < 10; i++) frame(8'd0, 10'd50, 1'b0);
    frame(8'h2C, 10'd77, 1'b0);
    idle_out(10'd77);

    // held key for 200 frames
    drain();
    base = dut_fires;
    for (int i = 0; i < 200; i++) frame(8'h2C, 10'd200, 1'b0);
    drain();
    check("held_fires", dut_fires - base, AUTO ? 2 : 1);
    idle_out(10'd200);

    // hit while idle does nothing
    for (int i = 0; i < 5; i++) frame(8'd0, 10'd200, 1'b1);

    // randomized frames, including X wrap near 1023
    for (int i = 0; i < 1500; i++) begin
      rk = ($urandom_range(0, 9) < 3) ? 8'h2C : 8'($urandom_range(0, 255));
      frame(rk, 10'($urandom_range(0, 1023)), ($urandom_range(0, 19) == 0));
    end
    idle_out(10'd1020);
    frame(8'h2C, 10'd1020, 1'b0);

    // asynchronous reset mid-flight
    fly_to(200, 10'd1020);
    drain();
    check("pre_reset_active", {31'd0, laser_active}, 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(negedge frame_clk);
    Reset = 1'b0;
    frame(8'h2C, 10'd5, 1'b0);
    frame(8'd0, 10'd5, 1'b0);
    drain();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
